// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin PCI bus arbiter with bus-idle tracking,
// preemption of long owners and revocation of grants that never start a cycle.
module pci_bus_arbiter #(
    parameter int NUM_MASTERS   = 4,
    parameter int OWNER_W       = 2,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [NUM_MASTERS-1:0] Req,
    input  logic                   Frame,
    input  logic                   IRDY,
    output logic [NUM_MASTERS-1:0] Gnt,
    output logic [OWNER_W-1:0]     Owner,
    output logic                   Timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY, SWITCH} state_t;

    state_t                 state, state_nx;
    logic [NUM_MASTERS-1:0] gnt_nx;
    logic [OWNER_W-1:0]     owner_nx, last, last_nx, winner, idx;
    logic [7:0]             timer, timer_nx;
    logic                   timeout_nx, found, others_req, bus_idle;

    assign bus_idle   = Frame & IRDY;
    assign others_req = |(~Req & ~(NUM_MASTERS'(1) << Owner));

    // Scan downward so the nearest requester after last overwrites farther ones.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = OWNER_W'((int'(last) + i) % NUM_MASTERS);
            if (!Req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        gnt_nx     = Gnt;
        owner_nx   = Owner;
        last_nx    = last;
        timer_nx   = timer;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                gnt_nx = '1;
                if (found) begin
                    gnt_nx   = ~(NUM_MASTERS'(1) << winner);
                    owner_nx = winner;
                    timer_nx = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!Frame) begin
                    state_nx = BUSY;
                end else if (Req[Owner]) begin
                    gnt_nx   = '1;
                    state_nx = SWITCH;
                end else if (timer == 8'(GRANT_TIMEOUT - 1)) begin
                    gnt_nx     = '1;
                    timeout_nx = 1'b1;
                    state_nx   = SWITCH;
                end else begin
                    timer_nx = (timer == 8'hff) ? timer : timer + 8'd1;
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    gnt_nx   = '1;
                    state_nx = SWITCH;
                end else if (others_req || Req[Owner]) begin
                    gnt_nx = '1;
                end
            end
            SWITCH: begin
                gnt_nx   = '1;
                last_nx  = Owner;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            Gnt     <= '1;
            Owner   <= '0;
            Timeout <= 1'b0;
            timer   <= '0;
            last    <= OWNER_W'(NUM_MASTERS - 1);
        end else begin
            state   <= state_nx;
            Gnt     <= gnt_nx;
            Owner   <= owner_nx;
            Timeout <= timeout_nx;
            timer   <= timer_nx;
            last    <= last_nx;
        end
    end
endmodule

// File: tb/tb_pci_bus_arbiter.sv
// tb_pci_bus_arbiter: directed scenarios plus randomized traffic against a
// behavioural tenure model of the arbiter.
module tb_pci_bus_arbiter;
    localparam int N  = 4;
    localparam int OW = 2;
    localparam int GT = 16;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [N-1:0]  Req = '1;
    logic          Frame = 1'b1;
    logic          IRDY = 1'b1;
    logic [N-1:0]  Gnt;
    logic [OW-1:0] Owner;
    logic          Timeout;

    int vectors = 0;
    int errors  = 0;

    // Model: granted master (-1 = none), owner, last owner, tenure phase
    // (0 waiting, 1 granted, 2 transferring, 3 dead cycle), cycles granted idle.
    int m_gnt, m_owner, m_last, m_phase, m_wait, m_to;

    always #5 Clk = ~Clk;

    pci_bus_arbiter #(.NUM_MASTERS(N), .OWNER_W(OW), .GRANT_TIMEOUT(GT)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Frame(Frame), .IRDY(IRDY),
        .Gnt(Gnt), .Owner(Owner), .Timeout(Timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = -1; m_owner = 0; m_last = N - 1; m_phase = 0; m_wait = 0; m_to = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        m_to = 0;
        case (m_phase)
            0: for (int k = 1; k <= N; k++) begin
                if (!Req[(m_last + k) % N]) begin
                    m_gnt = (m_last + k) % N; m_owner = m_gnt; m_wait = 0; m_phase = 1;
                    break;
                end
            end
            1: if (!Frame) m_phase = 2;
               else if (Req[m_owner]) begin m_gnt = -1; m_phase = 3; end
               else if (m_wait == GT - 1) begin m_to = 1; m_gnt = -1; m_phase = 3; end
               else m_wait++;
            2: begin
                others = ~Req;
                others[m_owner] = 1'b0;
                if (Frame && IRDY) begin m_gnt = -1; m_phase = 3; end
                else if (Req[m_owner] || others != '0) m_gnt = -1;
            end
            default: begin m_gnt = -1; m_last = m_owner; m_phase = 0; end
        endcase
    endtask

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v = '1;
        if (m_gnt >= 0) v[m_gnt] = 1'b0;
        return v;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic f, input logic i);
        Req = r; Frame = f; IRDY = i;
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        check("gnt", Gnt, exp_gnt());
        check("owner", Owner, m_owner);
        check("timeout", Timeout, m_to);
        check("gnt_onehot", $countones(~Gnt) <= 1, 1);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b0;
        drive('1, 1'b1, 1'b1);
        model_reset();
        #2;
        check("rst_gnt", Gnt, 4'b1111);
        check("rst_owner", Owner, 0);
        check("rst_timeout", Timeout, 0);
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    initial begin
        int gap, low, seen;
        int order[5] = '{0, 1, 2, 3, 0};

        do_reset();
        // single requester
        drive(4'b1101, 1, 1); cycle();
        check("single_gnt", Gnt, 4'b1101);
        check("single_owner", Owner, 1);
        drive(4'b1101, 0, 0);
        repeat (3) cycle();
        check("single_busy", Gnt, 4'b1101);
        drive(4'b1111, 1, 1); cycle();
        check("single_switch", Gnt, 4'b1111);
        cycle();
        check("single_idle", Gnt, 4'b1111);

        // fairness
        do_reset();
        drive(4'b0000, 1, 1);
        seen = 0;
        while (Gnt == 4'b1111 && seen < 10) begin cycle(); seen++; end
        for (int t = 0; t < 5; t++) begin
            check("fair_owner", Owner, order[t]);
            drive(4'b0000, 0, 0); cycle(); cycle();
            drive(4'b0000, 1, 1);
            if (t < 4) begin
                gap = 0;
                cycle();
                while (Gnt == 4'b1111 && gap < 20) begin gap++; cycle(); end
                check("fair_gap", gap, 2);
            end
        end

        // grant timeout
        do_reset();
        drive(4'b1011, 1, 1); cycle();
        low = 1;
        cycle();
        while (Gnt == 4'b1011 && low < 40) begin low++; cycle(); end
        check("to_len", low, GT);
        check("to_pulse", Timeout, 1);
        check("to_gnt", Gnt, 4'b1111);
        cycle();
        check("to_pulse_end", Timeout, 0);
        cycle(); cycle();
        check("to_regrant", Gnt, 4'b1011);

        // preemption
        do_reset();
        drive(4'b1110, 1, 1); cycle();
        drive(4'b1110, 0, 0); cycle();
        drive(4'b0110, 0, 0); cycle();
        check("pre_revoke", Gnt, 4'b1111);
        cycle();
        drive(4'b0110, 1, 1); cycle(); cycle(); cycle();
        check("pre_next", Gnt, 4'b0111);

        // withdrawal
        do_reset();
        drive(4'b1101, 1, 1); cycle();
        drive(4'b1111, 1, 1); cycle();
        check("wd_gnt", Gnt, 4'b1111);
        check("wd_timeout", Timeout, 0);
        cycle();
        drive(4'b0000, 1, 1); cycle();
        check("wd_next", Owner, 2);

        // asynchronous reset mid-transfer
        do_reset();
        drive(4'b1011, 1, 1); cycle();
        drive(4'b1011, 0, 0); cycle();
        #3 Rst = 1'b0;
        #1;
        check("arst_gnt", Gnt, 4'b1111);
        check("arst_owner", Owner, 0);
        check("arst_timeout", Timeout, 0);
        model_reset();
        drive(4'b0101, 1, 1);
        @(negedge Clk) Rst = 1'b1;
        cycle();
        check("arst_first", Owner, 1);

        // randomized traffic in three regimes: mixed, never-started, long bursts
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int mode = (i / 200) % 3;
            if ($urandom_range(0, 7) == 0) Req = N'($urandom);
            case (mode)
                0: begin Frame = $urandom_range(0, 2) != 0; IRDY = $urandom_range(0, 1) != 0; end
                1: begin Frame = 1'b1; IRDY = 1'b1; end
                default: begin Frame = $urandom_range(0, 5) == 0; IRDY = $urandom_range(0, 5) == 0; end
            endcase
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
- Central arbiter for the shared PCI bus on which the target devices sit.
- Collects active-low REQ# lines from up to NUM_MASTERS initiators and grants the bus round-robin via active-low GNT#.
- Tracks Frame/IRDY to detect bus idle, preempts long owners, and recovers from granted masters that never start a cycle.

Parameters:
- NUM_MASTERS, 4: number of requesting initiators (2..8).
- OWNER_W, 2: width of Owner; equals ceil(log2(NUM_MASTERS)).
- GRANT_TIMEOUT, 16: number of grant cycles allowed without Frame assertion before the grant is revoked (2..255).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  asynchronous reset, active-low.
- Req  in  NUM_MASTERS  bus requests, active-low, one per master.
- Frame  in  1  PCI FRAME#, active-low.
- IRDY  in  1  PCI IRDY#, active-low.
- Gnt  out  NUM_MASTERS  bus grants, active-low, registered, at most one bit low.
- Owner  out  OWNER_W  index of the currently or most recently granted master.
- Timeout  out  1  one-cycle active-high pulse when a grant is revoked for timeout.

Behaviour:
- Reset (Rst=0, asynchronous, no clock needed):
  - Gnt = all ones; Owner = 0; Timeout = 0; state = IDLE; timer = 0.
  - Round-robin pointer Last = NUM_MASTERS-1, so master 0 has first priority.
- All outputs are registered. Gnt never has more than one bit low.
- Bus idle is defined as Frame=1 and IRDY=1, sampled at posedge.
- IDLE:
  - Gnt all ones.
  - If any Req bit is low, winner = first low Req index searching (Last+1) mod N upward with wrap.
  - Next edge: Gnt[winner]=0, Owner=winner, timer=0, go to GRANT.
  - No request: stay in IDLE. There is no bus parking.
  - Request-to-grant latency: Gnt is low in the cycle after Req is first sampled low.
- GRANT (priority order, evaluated each edge):
  - Frame=0 sampled: go to BUSY; Gnt unchanged.
  - Req[Owner]=1 (request withdrawn): Gnt all ones, go to SWITCH; no Timeout.
  - timer==GRANT_TIMEOUT-1 with Frame=1: Timeout=1 for exactly one cycle, Gnt all ones, go to SWITCH.
  - Otherwise: timer+1. Gnt stays low for exactly GRANT_TIMEOUT cycles in the timeout case.
- BUSY:
  - If bus idle is sampled: Gnt all ones, go to SWITCH.
  - Otherwise, if any other master has Req low, or Req[Owner]=1: Gnt all ones (preemption, so the owner finishes its current transaction), stay in BUSY.
  - Otherwise: keep Gnt[Owner]=0.
  - Once Gnt is deasserted in BUSY it is not reasserted within the same tenure.
- SWITCH:
  - One dead cycle with Gnt all ones; Last=Owner; go to IDLE.
  - Guarantees at least two clocks of all-ones Gnt between tenures (SWITCH plus the IDLE decision cycle).
- Owner holds its value through SWITCH and IDLE until the next grant.
- Simultaneous events:
  - In GRANT, Frame=0 takes priority over withdrawal and timeout in the same cycle.
  - In BUSY, bus idle takes priority over preemption.
- Req changes in IDLE are taken only from the sampled value; there is no combinational Req-to-Gnt path.
- timer is 8 bits and saturates; it is only meaningful in GRANT.
- Reset mid-operation (any state): immediate return to reset values. The winner after reset is the lowest-index requester.

Test Plan:
- Single requester: after reset, Req=4'b1101 → next edge Gnt=4'b1101, Owner=1. Drive Frame=0 for 3 cycles, then Frame=1/IRDY=1 → SWITCH with Gnt=4'b1111, then IDLE. Timeout stays 0 throughout.
- Fairness: all Req=4'b0000 held, each master runs a 2-cycle Frame burst → grant order 0,1,2,3,0. Each tenure is separated by 2 cycles of Gnt=4'b1111.
- Timeout: only master 2 requests (Req=4'b1011), Frame held 1 → Gnt=4'b1011 for exactly 16 cycles. Timeout pulses for 1 cycle coincident with Gnt returning to 4'b1111. Master 2 is re-granted after SWITCH and IDLE.
- Preemption: master 0 in BUSY with Frame=0, master 3 drives Req=4'b0110 → Gnt=4'b1111 on the next edge while Frame is still 0. Gnt=4'b0111 appears only after bus idle is sampled, plus SWITCH and IDLE.
- Withdrawal: master 1 granted, Req[1] returns to 1 before Frame → Gnt=4'b1111 on the next edge, Timeout=0, and Last=1 so master 2 has priority next.
- Asynchronous reset: assert Rst=0 mid-BUSY between clock edges → Gnt=4'b1111, Owner=0, Timeout=0 immediately. After release with Req=4'b0101, master 1 is granted first.
